// File: rtl/imem_loader.sv
// imem_loader: receives a program over a valid/ready word stream and writes it
// into instruction memory, checks it against a trailing additive checksum
// word, and releases the processor core from reset once the load is verified.
//
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   i_start/i_count  start a load session of i_count words (1..2^ADDR_W)
//   i_valid/i_word   source word stream (program words, then checksum word)
//   o_ready          loader accepts i_word this cycle (LOAD or CHECK)
//   o_wrEn/Addr/Data instruction memory write port, one cycle after transfer
//   o_procReset      holds the core in reset except while running
//   o_done/o_error   load verified / bad count or checksum mismatch
//   o_checksum       running modulo-2^DATA_W sum of the program words
module imem_loader #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_count,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_word,
  output logic              o_ready,
  output logic              o_wrEn,
  output logic [ADDR_W-1:0] o_wrAddr,
  output logic [DATA_W-1:0] o_wrData,
  output logic              o_procReset,
  output logic              o_done,
  output logic              o_error,
  output logic [DATA_W-1:0] o_checksum
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  // Largest legal count is the full memory depth, 2^ADDR_W.
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              ready_q;
  logic              proc_reset_q;
  logic              done_q;
  logic              error_q;
  logic              xfer;
  logic              count_ok;

  assign xfer     = i_valid & ready_q;
  assign count_ok = (i_count != '0) && (i_count <= MAX_CNT);

  // Next-state, counters, checksum and write-port update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    chk_d     = chk_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      LOAD: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = i_word;
          cnt_d     = cnt_q + CNT_ONE;
          chk_d     = chk_q + i_word;
          if ((cnt_q + CNT_ONE) == len_q) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          state_d = (i_word == chk_q) ? RUN : ERROR;
        end
      end
      // IDLE, RUN, ERROR (and any unused encoding) accept a new session.
      default: begin
        if (i_start) begin
          if (count_ok) begin
            state_d = LOAD;
            len_d   = i_count;
            cnt_d   = '0;
            chk_d   = '0;
          end else begin
            state_d = ERROR;
          end
        end
      end
    endcase
  end

  // State and registered outputs; status flags are decoded from the next state
  // so they change in the same cycle the new state becomes visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      chk_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      ready_q      <= 1'b0;
      proc_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      ready_q      <= (state_d == LOAD) || (state_d == CHECK);
      proc_reset_q <= (state_d != RUN);
      done_q       <= (state_d == RUN);
      error_q      <= (state_d == ERROR);
    end
  end

  assign o_ready     = ready_q;
  assign o_wrEn      = wr_en_q;
  assign o_wrAddr    = wr_addr_q;
  assign o_wrData    = wr_data_q;
  assign o_procReset = proc_reset_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_checksum  = chk_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with hand-computed expected values.
module tb_imem_loader;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_start = 1'b0;
  logic [ADDR_W:0]   i_count = '0;
  logic              i_valid = 1'b0;
  logic [DATA_W-1:0] i_word = '0;
  logic              o_ready;
  logic              o_wrEn;
  logic [ADDR_W-1:0] o_wrAddr;
  logic [DATA_W-1:0] o_wrData;
  logic              o_procReset;
  logic              o_done;
  logic              o_error;
  logic [DATA_W-1:0] o_checksum;

  int n_checks = 0;
  int n_errors = 0;
  int wr_seen  = 0;

  imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_count     (i_count),
    .i_valid     (i_valid),
    .i_word      (i_word),
    .o_ready     (o_ready),
    .o_wrEn      (o_wrEn),
    .o_wrAddr    (o_wrAddr),
    .o_wrData    (o_wrData),
    .o_procReset (o_procReset),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_checksum  (o_checksum)
  );

  always #5 clk = ~clk;

  // Count write strobes mid-cycle; each pulse lasts exactly one cycle.
  always @(negedge clk) begin
    if (o_wrEn === 1'b1) wr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sess(input int c);
    i_start = 1'b1;
    i_count = 7'(c);
    tick();
    i_start = 1'b0;
    i_count = '0;
  endtask

  // Offer one word, wait for the transfer edge, then check the write port.
  task automatic send(input logic [DATA_W-1:0] w, input bit is_prog, input int exp_addr,
                      input string tag);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_word  = w;
    while (o_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      i_valid = 1'b0;
      check({tag, "_ready_timeout"}, 32'(o_ready), 32'd1);
    end else begin
      tick();
      i_valid = 1'b0;
      if (is_prog) begin
        check({tag, "_wren"}, 32'(o_wrEn), 32'd1);
        check({tag, "_addr"}, 32'(o_wrAddr), 32'(exp_addr));
        check({tag, "_data"}, 32'(o_wrData), 32'(w));
      end else begin
        check({tag, "_nowr"}, 32'(o_wrEn), 32'd0);
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_wren"},  32'(o_wrEn), 32'd0);
    check({tag, "_addr"},  32'(o_wrAddr), 32'd0);
    check({tag, "_data"},  32'(o_wrData), 32'd0);
    check({tag, "_prst"},  32'(o_procReset), 32'd1);
    check({tag, "_done"},  32'(o_done), 32'd0);
    check({tag, "_err"},   32'(o_error), 32'd0);
    check({tag, "_csum"},  32'(o_checksum), 32'd0);
  endtask

  task automatic check_status(input string tag, input bit rdy, input bit prst, input bit dn,
                              input bit er);
    check({tag, "_ready"}, 32'(o_ready), 32'(rdy));
    check({tag, "_prst"},  32'(o_procReset), 32'(prst));
    check({tag, "_done"},  32'(o_done), 32'(dn));
    check({tag, "_err"},   32'(o_error), 32'(er));
  endtask

  initial begin
    int w0;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] w;

    // Asynchronous reset, checked before the first clock edge.
    #1 reset = 1'b1;
    #2;
    check_reset_outs("rst");
    tick();
    reset = 1'b0;
    tick();
    check_reset_outs("idle");

    // Three words with carry wrap: 1 + 2 + 0x1FFF = 0x0002.
    start_sess(3);
    check_status("t34_load", 1'b1, 1'b1, 1'b0, 1'b0);
    check("t34_csum0", 32'(o_checksum), 32'd0);
    send(13'h0001, 1'b1, 0, "t34_w0");
    send(13'h0002, 1'b1, 1, "t34_w1");
    send(13'h1FFF, 1'b1, 2, "t34_w2");
    check("t34_csum", 32'(o_checksum), 32'h0002);
    check("t34_chkready", 32'(o_ready), 32'd1);
    send(13'h0002, 1'b0, 0, "t34_ck");
    check_status("t34_run", 1'b0, 1'b0, 1'b1, 1'b0);

    // i_valid with o_ready low is ignored.
    w0 = wr_seen;
    i_valid = 1'b1;
    i_word  = 13'h0555;
    repeat (3) tick();
    i_valid = 1'b0;
    tick();
    check("ign_wr", 32'(wr_seen - w0), 32'd0);
    check("ign_csum", 32'(o_checksum), 32'h0002);
    check_status("ign_run", 1'b0, 1'b0, 1'b1, 1'b0);

    // Zero count from RUN goes to ERROR without writes.
    w0 = wr_seen;
    start_sess(0);
    check_status("t36_c0", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("t36_c0_wr", 32'(wr_seen - w0), 32'd0);

    // Same program with a wrong checksum word; LOAD entry clears the error.
    start_sess(3);
    check_status("t35_load", 1'b1, 1'b1, 1'b0, 1'b0);
    send(13'h0001, 1'b1, 0, "t35_w0");
    send(13'h0002, 1'b1, 1, "t35_w1");
    send(13'h1FFF, 1'b1, 2, "t35_w2");
    send(13'h0003, 1'b0, 0, "t35_ck");
    check_status("t35_err", 1'b0, 1'b1, 1'b0, 1'b1);

    // Full 64-word program with gaps in i_valid.
    w0  = wr_seen;
    sum = '0;
    start_sess(64);
    check_status("t37_load", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      w   = 13'((i * 37 + 5) * 11);
      sum = sum + w;
      send(w, 1'b1, i, $sformatf("t37_w%0d", i));
      repeat (i % 3) tick();
    end
    check("t37_csum", 32'(o_checksum), 32'(sum));
    send(sum, 1'b0, 0, "t37_ck");
    tick();
    check("t37_nwr", 32'(wr_seen - w0), 32'd64);
    check_status("t37_run", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reload from RUN; a start during LOAD is ignored.
    start_sess(2);
    check_status("t39_load", 1'b1, 1'b1, 1'b0, 1'b0);
    check("t39_csum0", 32'(o_checksum), 32'd0);
    send(13'h0100, 1'b1, 0, "t39_w0");
    start_sess(7);
    check("t39_ign_ready", 32'(o_ready), 32'd1);
    check("t39_ign_csum", 32'(o_checksum), 32'h0100);
    send(13'h0200, 1'b1, 1, "t39_w1");
    send(13'h0300, 1'b0, 0, "t39_ck");
    check_status("t39_run", 1'b0, 1'b0, 1'b1, 1'b0);

    // Count above the memory depth from RUN goes to ERROR without writes.
    w0 = wr_seen;
    start_sess(65);
    check_status("t36_c65", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("t36_c65_wr", 32'(wr_seen - w0), 32'd0);

    // Reset in the middle of a load, then a fresh one-word session.
    start_sess(5);
    send(13'h0AAA, 1'b1, 0, "t38_w0");
    send(13'h0555, 1'b1, 1, "t38_w1");
    reset = 1'b1;
    #2;
    check_reset_outs("t38_rst");
    tick();
    reset = 1'b0;
    tick();
    start_sess(1);
    check("t38_csum0", 32'(o_checksum), 32'd0);
    send(13'h0123, 1'b1, 0, "t38_n0");
    check("t38_csum", 32'(o_checksum), 32'h0123);
    send(13'h0123, 1'b0, 0, "t38_ck");
    check_status("t38_run", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
